// File: rtl/ball_engine.sv
// ball_engine: single-ball pong engine with paddle hits, scoring and a serve/score/game-over FSM
module ball_engine #(
    parameter int W          = 10,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int BALL_R     = 6,
    parameter int PAD_HALF_H = 20,
    parameter int LEFT_PAD_X = 100,
    parameter int RIGHT_PAD_X = 540,
    parameter int TICK_DIV   = 18,
    parameter int MAX_SPEED  = 4,
    parameter int HOLD_TICKS = 32,
    parameter int WIN_SCORE  = 7
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         serve,
    input  logic [W-1:0] left_paddle_pos,
    input  logic [W-1:0] right_paddle_pos,
    output logic [W-1:0] ball_x_pos,
    output logic [W-1:0] ball_y_pos,
    output logic [3:0]   score_left,
    output logic [3:0]   score_right,
    output logic [1:0]   state_o,
    output logic         hit_pulse,
    output logic         point_pulse
);
    typedef enum logic [1:0] {IDLE, PLAY, SCORED, GAME_OVER} state_t;
    typedef logic signed [W+1:0] s_t;
    localparam int SPW = $clog2(MAX_SPEED + 1);
    localparam int HW  = $clog2(HOLD_TICKS + 1);
    localparam logic [W-1:0] CX = W'(SCREEN_W / 2);
    localparam logic [W-1:0] CY = W'(SCREEN_H / 2);
    localparam s_t R    = s_t'(BALL_R);
    localparam s_t PH   = s_t'(PAD_HALF_H);
    localparam s_t LPX  = s_t'(LEFT_PAD_X);
    localparam s_t RPX  = s_t'(RIGHT_PAD_X);
    localparam s_t XR   = s_t'(SCREEN_W - 1);
    localparam s_t YB   = s_t'(SCREEN_H - 1);
    localparam s_t XMAX = s_t'(SCREEN_W - 1 - BALL_R);
    localparam s_t YMAX = s_t'(SCREEN_H - 1 - BALL_R);

    state_t         state_q, state_d;
    logic [TICK_DIV-1:0] cnt_q, cnt_d;
    logic [W-1:0]   x_q, x_d, y_q, y_d;
    logic           dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [SPW-1:0] speed_q, speed_d;
    logic [3:0]     score_l_q, score_l_d, score_r_q, score_r_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           hit_q, hit_d, point_q, point_d;

    logic tick, miss_r, miss_l, hit_r, hit_l, y_flip;
    s_t   sx, sy, spd, lp, rp, x_fwd, x_back, x_step, y_step;

    assign tick   = &cnt_q;
    assign cnt_d  = cnt_q + TICK_DIV'(1);
    assign sx     = s_t'(x_q);
    assign sy     = s_t'(y_q);
    assign spd    = s_t'(speed_q);
    assign lp     = s_t'(left_paddle_pos);
    assign rp     = s_t'(right_paddle_pos);
    assign miss_r = dir_x_q && sx + R >= XR;
    assign miss_l = !dir_x_q && sx <= R;
    assign hit_r  = dir_x_q && sx + R >= RPX && sx <= RPX && sy + R >= rp - PH && sy - R <= rp + PH;
    assign hit_l  = !dir_x_q && sx - R <= LPX && sx >= LPX && sy + R >= lp - PH && sy - R <= lp + PH;
    assign x_fwd  = sx + spd;
    assign x_back = sx - spd;
    assign x_step = dir_x_q ? (x_fwd > XMAX ? XMAX : x_fwd) : (x_back < R ? R : x_back);
    assign y_flip = dir_y_q ? (sy + R + spd >= YB) : (sy <= R + spd);
    assign y_step = y_flip ? (dir_y_q ? YMAX : R) : (dir_y_q ? sy + spd : sy - spd);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        speed_d   = speed_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        hold_d    = hold_q;
        hit_d     = 1'b0;
        point_d   = 1'b0;
        case (state_q)
            IDLE: begin
                x_d = CX;
                y_d = CY;
                if (serve) begin
                    state_d = PLAY;
                    speed_d = SPW'(1);
                end
            end
            PLAY: if (tick) begin
                if (miss_r || miss_l) begin
                    state_d   = SCORED;
                    point_d   = 1'b1;
                    hold_d    = '0;
                    score_l_d = miss_r ? score_l_q + 4'd1 : score_l_q;
                    score_r_d = miss_l ? score_r_q + 4'd1 : score_r_q;
                end else if (hit_r || hit_l) begin
                    dir_x_d = !dir_x_q;
                    speed_d = speed_q == SPW'(MAX_SPEED) ? speed_q : speed_q + SPW'(1);
                    hit_d   = 1'b1;
                end else begin
                    x_d = x_step[W-1:0];
                end
                y_d     = y_step[W-1:0];
                dir_y_d = dir_y_q ^ y_flip;
            end
            SCORED: if (tick) begin
                hold_d = hold_q + HW'(1);
                // dir_x still points at the conceding side, so the next serve goes toward them
                if (hold_q == HW'(HOLD_TICKS - 1)) begin
                    state_d = (score_l_q == 4'(WIN_SCORE) || score_r_q == 4'(WIN_SCORE)) ? GAME_OVER : IDLE;
                    x_d     = CX;
                    y_d     = CY;
                    speed_d = SPW'(1);
                    hold_d  = '0;
                end
            end
            default: begin
                x_d = CX;
                y_d = CY;
                if (serve) begin
                    state_d   = IDLE;
                    score_l_d = '0;
                    score_r_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            x_q       <= CX;
            y_q       <= CY;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            speed_q   <= SPW'(1);
            score_l_q <= '0;
            score_r_q <= '0;
            hold_q    <= '0;
            hit_q     <= 1'b0;
            point_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            speed_q   <= speed_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            hold_q    <= hold_d;
            hit_q     <= hit_d;
            point_q   <= point_d;
        end
    end

    assign ball_x_pos  = x_q;
    assign ball_y_pos  = y_q;
    assign score_left  = score_l_q;
    assign score_right = score_r_q;
    assign state_o     = state_q;
    assign hit_pulse   = hit_q;
    assign point_pulse = point_q;
endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: directed game scenarios with hand-computed ball positions, scores and pulses
module tb_ball_engine;
    localparam int W = 10;
    logic clk = 1'b0, reset_n = 1'b0, serve = 1'b0, track = 1'b0;
    logic [W-1:0] lp = '0, rp = '0, rpad, bx, by;
    logic [3:0] sl, sr;
    logic [1:0] st;
    logic hit, pnt;
    int checks = 0, failures = 0;

    assign rpad = track ? by : rp;

    ball_engine #(.TICK_DIV(2), .WIN_SCORE(2)) dut (
        .clk(clk), .reset_n(reset_n), .serve(serve),
        .left_paddle_pos(lp), .right_paddle_pos(rpad),
        .ball_x_pos(bx), .ball_y_pos(by),
        .score_left(sl), .score_right(sr), .state_o(st),
        .hit_pulse(hit), .point_pulse(pnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (4 * n) @(posedge clk);
        #1;
    endtask

    task automatic serve_pulse();
        serve = 1'b1;
        @(posedge clk);
        #1;
        serve = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", st, 0);
        check("rst_x", bx, 320);
        check("rst_y", by, 240);
        check("rst_sl", sl, 0);
        check("rst_sr", sr, 0);
        check("rst_hit", hit, 0);
        check("rst_pnt", pnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        ticks(100);
        check("idle_x", bx, 320);
        check("idle_y", by, 240);
        check("idle_state", st, 0);
        check("idle_sl", sl, 0);
        repeat (3) @(posedge clk);
        #1;
        serve = 1'b1;
        @(posedge clk);
        #1;
        serve = 1'b0;
        check("serve_on_tick_x", bx, 320);
        check("serve_state", st, 1);
        ticks(3);
        check("play3_x", bx, 323);
        check("play3_y", by, 243);
        check("play3_state", st, 1);
        ticks(229);
        check("bot_pre_y", by, 472);
        ticks(1);
        check("bot_clamp_y", by, 473);
        ticks(1);
        check("bot_after_y", by, 472);
        ticks(79);
        check("edge_x", bx, 633);
        check("edge_state", st, 1);
        ticks(1);
        check("miss_x", bx, 633);
        check("miss_sl", sl, 1);
        check("miss_sr", sr, 0);
        check("miss_pnt", pnt, 1);
        check("miss_hit", hit, 0);
        check("miss_state", st, 2);
        @(posedge clk);
        #1;
        check("pnt_width", pnt, 0);
        repeat (3) @(posedge clk);
        #1;
        ticks(30);
        check("hold31_state", st, 2);
        check("hold31_x", bx, 633);
        ticks(1);
        check("hold32_state", st, 0);
        check("hold32_x", bx, 320);
        check("hold32_y", by, 240);
        lp = 10'd300;
        rp = 10'd300;
        serve_pulse();
        check("serve2_state", st, 1);
        repeat (3) @(posedge clk);
        #1;
        check("serve2_x", bx, 321);
        check("serve2_y", by, 239);
        serve = 1'b1;
        ticks(1);
        serve = 1'b0;
        check("serve_ignored_state", st, 1);
        check("serve_ignored_x", bx, 322);
        ticks(231);
        check("top_pre_y", by, 7);
        ticks(1);
        check("top_clamp_y", by, 6);
        ticks(1);
        check("top_after_y", by, 7);
        ticks(78);
        check("edge2_x", bx, 633);
        ticks(1);
        check("miss2_sl", sl, 2);
        check("miss2_state", st, 2);
        ticks(32);
        check("over_state", st, 3);
        check("over_x", bx, 320);
        check("over_y", by, 240);
        check("over_sl", sl, 2);
        check("over_sr", sr, 0);
        serve_pulse();
        check("restart_state", st, 0);
        check("restart_sl", sl, 0);
        check("restart_sr", sr, 0);
        repeat (3) @(posedge clk);
        #1;
        track = 1'b1;
        serve_pulse();
        check("serve3_state", st, 1);
        repeat (3) @(posedge clk);
        #1;
        check("serve3_x", bx, 321);
        check("serve3_y", by, 241);
        ticks(213);
        check("prehit_x", bx, 534);
        check("prehit_hit", hit, 0);
        ticks(1);
        check("hit_x", bx, 534);
        check("hit_pulse", hit, 1);
        check("hit_pnt", pnt, 0);
        @(posedge clk);
        #1;
        check("hit_width", hit, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rebound1_x", bx, 532);
        ticks(1);
        check("rebound2_x", bx, 530);
        check("rebound_state", st, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_state", st, 0);
        check("midrst_x", bx, 320);
        check("midrst_y", by, 240);
        check("midrst_sl", sl, 0);
        check("midrst_hit", hit, 0);
        check("midrst_pnt", pnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        serve = 1'b1;
        @(posedge clk);
        #1;
        serve = 1'b0;
        check("rst_serve_state", st, 1);
        repeat (2) @(posedge clk);
        #1;
        check("first_tick_pre_x", bx, 320);
        @(posedge clk);
        #1;
        check("first_tick_x", bx, 321);
        check("first_tick_y", by, 241);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
